// File: rtl/cam_entry_manager.sv
// -----------------------------------------------------------------------------
// cam_entry_manager
//
// Purpose:
//   Upstream controller for the BRAM CAM write port. Accepts insert and delete
//   requests over a valid/ready handshake, allocates the lowest free CAM entry
//   for each insert, drives exactly one CAM write sequence per request, tracks
//   entry occupancy and returns a response carrying the entry address and a
//   status code. Only one request is in flight at a time.
//
// Parameters:
//   DATA_WIDTH  key width, matches the CAM search data width
//   ADDR_WIDTH  log2 of the CAM entry count (N = 2**ADDR_WIDTH)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     request handshake
//   req_op              0 = insert, 1 = delete
//   req_data            key to insert (ignored for delete)
//   req_addr            entry to delete (ignored for insert)
//   rsp_valid/ready     response handshake
//   rsp_addr            allocated or deleted entry
//   rsp_status          0 = OK, 1 = FULL, 2 = INVALID, 3 = DUP
//   cam_write_*         CAM write port (addr/data/delete/enable out, busy in)
//   occupancy           number of valid entries, 0..N
//   full, empty         registered occupancy flags
//
// Build option:
//   CAM_MGR_DUP_CHECK_EN  when defined, keeps a shadow copy of every stored key
//                         and answers an insert of an already-present key with
//                         status DUP (checked before FULL) without a CAM write.
//                         When undefined, duplicate keys occupy new entries and
//                         status DUP is never produced.
// -----------------------------------------------------------------------------
module cam_entry_manager #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [1:0]            rsp_status,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [DATA_WIDTH-1:0] cam_write_data,
  output logic                  cam_write_delete,
  output logic                  cam_write_enable,
  input  logic                  cam_write_busy,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic                  full,
  output logic                  empty
);

  localparam int N = 1 << ADDR_WIDTH;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_FULL    = 2'd1;
  localparam logic [1:0] ST_INVALID = 2'd2;
  localparam logic [1:0] ST_DUP     = 2'd3;

  localparam logic OP_INSERT = 1'b0;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT_HI = 3'd3,
    S_WAIT_LO = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t                  r_state;
  state_t                  w_state_next;

  logic [N-1:0]            r_valid;
  logic [ADDR_WIDTH:0]     r_occ;
  logic                    r_full;
  logic                    r_empty;

  logic                    r_op;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [ADDR_WIDTH-1:0]   r_addr;

  logic [ADDR_WIDTH-1:0]   r_rsp_addr;
  logic [1:0]              r_rsp_status;

  // Control strobes from the next-state logic
  logic                    w_accept;
  logic                    w_commit;
  logic                    w_rsp_load;
  logic [ADDR_WIDTH-1:0]   w_rsp_addr_next;
  logic [1:0]              w_rsp_status_next;
  logic                    w_write_enable;

  logic [ADDR_WIDTH-1:0]   w_free_idx;
  logic [ADDR_WIDTH:0]     w_occ_next;
  logic                    w_dup_hit;
  logic [ADDR_WIDTH-1:0]   w_dup_idx;

  // ---------------------------------------------------------------------------
  // Lowest free entry. Scanning from the top down lets the lowest free index
  // win. When the table is full the result is unused (FULL path).
  // ---------------------------------------------------------------------------
  always_comb begin
    w_free_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_idx = ADDR_WIDTH'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional duplicate-key detection against a shadow copy of stored keys.
  // The shadow needs a parallel compare across all entries, so it is kept in
  // flops rather than a RAM. It has no reset: entries only count when their
  // valid bit is set, and the valid bitmap is cleared by reset.
  // ---------------------------------------------------------------------------
`ifdef CAM_MGR_DUP_CHECK_EN
  logic [DATA_WIDTH-1:0] r_shadow [N];
  logic [N-1:0]          w_match;

  for (genvar gi = 0; gi < N; gi++) begin : g_match
    assign w_match[gi] = r_valid[gi] && (r_shadow[gi] == req_data);
  end

  always_ff @(posedge clk) begin
    if (w_commit && (r_op == OP_INSERT)) begin
      r_shadow[r_addr] <= r_data;
    end
  end

  always_comb begin
    w_dup_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_dup_idx = ADDR_WIDTH'(i);
      end
    end
  end

  assign w_dup_hit = |w_match;
`else
  assign w_dup_hit = 1'b0;
  assign w_dup_idx = '0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next      = r_state;
    w_accept          = 1'b0;
    w_commit          = 1'b0;
    w_rsp_load        = 1'b0;
    w_rsp_addr_next   = r_rsp_addr;
    w_rsp_status_next = r_rsp_status;
    w_write_enable    = 1'b0;

    case (r_state)
      // The CAM clears its RAMs after reset and holds busy meanwhile.
      S_INIT: begin
        if (!cam_write_busy) begin
          w_state_next = S_IDLE;
        end
      end

      S_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (req_op == OP_INSERT) begin
            // Duplicate detection outranks the full check so that a present
            // key is reported as DUP even when the table is full.
            if (w_dup_hit) begin
              w_rsp_load        = 1'b1;
              w_rsp_addr_next   = w_dup_idx;
              w_rsp_status_next = ST_DUP;
              w_state_next      = S_RESP;
            end else if (r_full) begin
              w_rsp_load        = 1'b1;
              w_rsp_addr_next   = '0;
              w_rsp_status_next = ST_FULL;
              w_state_next      = S_RESP;
            end else begin
              w_state_next = S_ISSUE;
            end
          end else begin
            if (!r_valid[req_addr]) begin
              w_rsp_load        = 1'b1;
              w_rsp_addr_next   = req_addr;
              w_rsp_status_next = ST_INVALID;
              w_state_next      = S_RESP;
            end else begin
              w_state_next = S_ISSUE;
            end
          end
        end
      end

      // Single-cycle enable pulse, only once the CAM is ready for it.
      S_ISSUE: begin
        if (!cam_write_busy) begin
          w_write_enable = 1'b1;
          w_state_next   = S_WAIT_HI;
        end
      end

      // busy rises the cycle after enable; wait for it so the falling edge
      // seen in WAIT_LO belongs to this write.
      S_WAIT_HI: begin
        if (cam_write_busy) begin
          w_state_next = S_WAIT_LO;
        end
      end

      S_WAIT_LO: begin
        if (!cam_write_busy) begin
          w_commit          = 1'b1;
          w_rsp_load        = 1'b1;
          w_rsp_addr_next   = r_addr;
          w_rsp_status_next = ST_OK;
          w_state_next      = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch. These registers drive the CAM write port directly, so they
  // stay stable from ISSUE through WAIT_LO.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= 1'b0;
      r_data <= '0;
      r_addr <= '0;
    end else if (w_accept) begin
      r_op   <= req_op;
      r_data <= req_data;
      r_addr <= (req_op == OP_INSERT) ? w_free_idx : req_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Response registers, held until the response is consumed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_addr   <= '0;
      r_rsp_status <= ST_OK;
    end else if (w_rsp_load) begin
      r_rsp_addr   <= w_rsp_addr_next;
      r_rsp_status <= w_rsp_status_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy bitmap: one flop per entry, touched only when a completed write
  // commits to its own index.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N; gi++) begin : g_valid
    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid[gi] <= 1'b0;
      end else if (w_commit && (r_addr == ADDR_WIDTH'(gi))) begin
        r_valid[gi] <= (r_op == OP_INSERT);
      end
    end
  end

  // Occupancy cannot wrap: inserts are refused when full and deletes of
  // empty entries are refused as INVALID before any commit happens.
  assign w_occ_next = (r_op == OP_INSERT) ? (r_occ + 1'b1) : (r_occ - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else if (w_commit) begin
      r_occ   <= w_occ_next;
      r_full  <= (w_occ_next == (ADDR_WIDTH + 1)'(N));
      r_empty <= (w_occ_next == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready        = (r_state == S_IDLE);
  assign rsp_valid        = (r_state == S_RESP);
  assign rsp_addr         = r_rsp_addr;
  assign rsp_status       = r_rsp_status;

  assign cam_write_addr   = r_addr;
  assign cam_write_data   = r_data;
  assign cam_write_delete = r_op;
  assign cam_write_enable = w_write_enable;

  assign occupancy        = r_occ;
  assign full             = r_full;
  assign empty            = r_empty;

endmodule

// File: doc/cam_entry_manager.md
Name: cam_entry_manager

Overview:
- Upstream controller for the BRAM CAM write port.
- Accepts insert/delete requests over a valid/ready handshake.
- Allocates a free CAM entry (lowest free index) for each insert and drives the CAM write port through one write sequence per request, honouring write busy.
- Tracks entry occupancy and returns a response carrying the entry address and a status code.

Parameters:
- DATA_WIDTH, 64, key width; matches the CAM's search data width.
- ADDR_WIDTH, 5, log2 of CAM entry count; the entry count N is 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_op  in  1  0=insert, 1=delete
- req_data  in  DATA_WIDTH  key to insert (ignored for delete)
- req_addr  in  ADDR_WIDTH  entry to delete (ignored for insert)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_addr  out  ADDR_WIDTH  allocated or deleted entry
- rsp_status  out  2  0=OK, 1=FULL, 2=INVALID, 3=DUP
- cam_write_addr  out  ADDR_WIDTH  to CAM write_addr
- cam_write_data  out  DATA_WIDTH  to CAM write_data
- cam_write_delete  out  1  to CAM write_delete
- cam_write_enable  out  1  to CAM write_enable
- cam_write_busy  in  1  from CAM write_busy
- occupancy  out  ADDR_WIDTH+1  number of valid entries, 0..N
- full  out  1  occupancy==N
- empty  out  1  occupancy==0

Behaviour:
- Reset values:
  - FSM=INIT; valid bitmap all 0; occupancy=0; empty=1; full=0.
  - req_ready=0, rsp_valid=0, cam_write_enable=0.
  - cam_write_addr, cam_write_data, cam_write_delete = 0; rsp_addr=0, rsp_status=0.
- INIT:
  - Stay while cam_write_busy=1; the CAM clears its RAMs after reset.
  - Go to IDLE on the first cycle cam_write_busy=0.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op/data/addr into registers; req_ready drops next cycle.
  - Insert with full=1: status FULL, rsp_addr=0, go to RESP, no CAM write.
  - Delete with valid[req_addr]=0: status INVALID, rsp_addr=req_addr, go to RESP, no CAM write.
  - Otherwise go to ISSUE. For insert, the target is the lowest-index free entry, computed combinationally from ~valid.
- ISSUE:
  - cam_write_addr/data/delete are already driven from the latched registers.
  - Assert cam_write_enable for exactly one cycle, only if cam_write_busy=0; otherwise wait here.
  - Go to WAIT_HI.
- WAIT_HI: wait for cam_write_busy=1 (it rises the cycle after enable). Timeout is not required.
- WAIT_LO:
  - Wait for cam_write_busy=0.
  - Then update the bitmap: insert sets valid[addr] and occupancy+1; delete clears valid[addr] and occupancy-1.
  - Set status OK and go to RESP.
- RESP:
  - rsp_valid=1; rsp_addr/rsp_status stay stable until rsp_ready.
  - On rsp_valid&rsp_ready go to IDLE.
  - Back-to-back minimum: one request per ~6 cycles plus the CAM's write latency.
- CAM write port outputs hold stable from ISSUE through WAIT_LO; the CAM samples the address continuously while idle.
- Only one request is in flight at a time; no pipelining of requests.
- full and empty are registered, derived from occupancy, and updated in the same cycle as occupancy.
- rst in any state:
  - Return to INIT and clear the bitmap and occupancy.
  - Any in-flight response is dropped.
  - The CAM is reset by the same rst, so the state stays consistent.
- Occupancy never wraps; the FULL and INVALID checks guarantee 0..N.

Optional Feature:
- Macro: CAM_MGR_DUP_CHECK_EN.
- When defined:
  - Keep a shadow key array of N×DATA_WIDTH, written in WAIT_LO on insert.
  - On insert, compare the key against all valid shadow entries in IDLE.
  - On a hit: status DUP, rsp_addr = lowest matching entry, no CAM write, go to RESP.
  - The DUP check takes priority over FULL.
- When undefined: no shadow array; duplicate keys are inserted into new entries and status 3 is never produced.

Test Plan:
- Reset, CAM model holds busy 20 cycles -> req_ready=0 until busy falls, then req_ready=1; occupancy=0, empty=1.
- Insert keys 0xA5, 0x3C -> rsp_addr 0 then 1, status OK; each cam_write_enable is a 1-cycle pulse with cam_write_delete=0; occupancy=2.
- Delete addr 0, then insert 0x77 -> delete status OK with cam_write_delete=1; insert reuses addr 0; occupancy=2.
- Fill all 32 entries, then insert again -> status FULL, rsp_addr=0, no enable pulse; full=1. Delete addr 7 (status OK, full=0); delete addr 7 again -> status INVALID.
- Hold rsp_ready=0 for 10 cycles after an insert -> rsp_valid, rsp_addr and rsp_status stable, req_ready=0 throughout; assert rst mid-WAIT_LO -> INIT, occupancy=0.
- With CAM_MGR_DUP_CHECK_EN: insert 0xA5 twice -> second response status DUP, rsp_addr = first entry, no enable pulse, occupancy unchanged.
